muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the MIPS multiply/divide unit and its HI/LO register pair.
- Sits beside the single-cycle ALU in EX and executes mult, multu, div and divu iteratively, one bit per cycle.
- Services mthi/mtlo writes and exposes HI/LO to the datapath for mfhi/mflo.
- Drives busy so the hazard unit can stall any HI/LO-dependent instruction.

---
 rtl/muldiv_seq_if.sv | 34 +++
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Bundle of the handshake and data signals between the EX stage / hazard unit
// and the multi-cycle multiply/divide sequencer.
//   master : datapath side  - drives start/op/src_a/src_b/hi_we/lo_we/wdata,
//                             observes busy/done/div_by_zero/hi/lo
//   slave  : muldiv_seq     - the reverse direction
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;          // 00 mult, 01 multu, 10 div, 11 divu
    logic [DATA_W-1:0] src_a;       // multiplicand / dividend
    logic [DATA_W-1:0] src_b;       // multiplier / divisor
    logic              hi_we;       // mthi
    logic              lo_we;       // mtlo
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative MIPS multiply/divide unit with the HI/LO register pair.
// Executes mult/multu (shift-add) and div/divu (restoring division) one bit
// per cycle, services mthi/mtlo while idle and exposes HI/LO for mfhi/mflo.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - muldiv_seq_if.slave: start/op/src_a/src_b/hi_we/lo_we/wdata in,
//          busy/done/div_by_zero/hi/lo out (all outputs registered)
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

    state_t              state_q;
    logic                is_div_q;
    logic                neg_res_q;    // product / quotient must be negated
    logic                neg_rem_q;    // remainder takes the dividend's sign
    logic [DATA_W-1:0]   opnd_q;       // multiplicand or divisor magnitude
    logic [2*DATA_W-1:0] acc_q;        // {hi part, lo part} / {remainder, quotient}
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                busy_q, done_q, dbz_q;

    // Start-cycle operand decode: signed ops work on magnitudes.
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    // One iteration of the datapath and the sign-corrected result.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [DATA_W-1:0]   res_hi_d, res_lo_d;

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        a_neg = ~bus.op[0] & bus.src_a[DATA_W-1];
        b_neg = ~bus.op[0] & bus.src_b[DATA_W-1];
        a_mag = a_neg ? -bus.src_a : bus.src_a;
        b_mag = b_neg ? -bus.src_b : bus.src_b;

        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + {1'b0, opnd_q & {DATA_W{acc_q[0]}}};

        // Divide: shift {rem, quo} left by one and try subtracting the divisor
        // from the widened remainder; keep the difference if it did not borrow.
        div_trial = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, opnd_q};

        if (is_div_q) begin
            if (div_trial[DATA_W])
                acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
            else
                acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

        res_hi_d = is_div_q ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
        res_lo_d = is_div_q ? quo_fix : prod_fix[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start has priority: concurrent mthi/mtlo are dropped
                        is_div_q <= bus.op[1];
                        if (bus.op[1] && bus.src_b == '0) begin
                            // zero divisor: no iteration, HI/LO untouched
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                        end else begin
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            opnd_q    <= bus.op[1] ? b_mag : a_mag;
                            acc_q     <= {{DATA_W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                            cnt_q     <= CNT_W'(DATA_W);
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                FIN: begin
                    // any start seen here is deliberately ignored
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed self-checking bench for muldiv_seq. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.DATA_W(32)) bus ();

    muldiv_seq #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mwrite(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = h;
        bus.lo_we = l;
        bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Launch one operation and follow it until done (bounded). k counts cycles
    // after the start cycle; optional interference is driven in cycle inj.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit we, input logic [31:0] wd, input int inj,
                          output int lat, output int busy_n, output bit dbz,
                          output bit hold_bad);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        bus.hi_we = we;
        bus.lo_we = we;
        bus.wdata = wd;
        lat = 0; busy_n = 0; dbz = 1'b0; hold_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            bus.op    = 2'b00;
            bus.src_a = 32'hDEAD_BEEF;
            bus.src_b = 32'h0BAD_F00D;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = k;
                dbz = bus.div_by_zero;
                break;
            end
            if (bus.hi !== h0 || bus.lo !== l0) hold_bad = 1'b1;
            if (k == inj) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.src_a = 32'h0000_1234;
                bus.src_b = 32'h0000_5678;
                bus.hi_we = 1'b1;
                bus.wdata = 32'h0000_0BAD;
            end
        end
    endtask

    int lat, busy_n, n_done;
    bit dbz, hold_bad;

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi",   bus.hi, 0);
        check("rst_lo",   bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz",  bus.div_by_zero, 0);

        // multu 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("multu_lat",  lat, 34);
        check("multu_busy", busy_n, 33);
        check("multu_dbz",  dbz, 0);
        check("multu_hold", hold_bad, 0);
        check("multu_hi",   bus.hi, 32'hFFFF_FFFE);
        check("multu_lo",   bus.lo, 32'h0000_0001);

        // mult -3 * 7 = -21
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("mult_lat", lat, 34);
        check("mult_hi",  bus.hi, 32'hFFFF_FFFF);
        check("mult_lo",  bus.lo, 32'hFFFF_FFEB);

        // div -7 / 2 = -3 rem -1
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("div_neg_lat", lat, 34);
        check("div_neg_lo",  bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi",  bus.hi, 32'hFFFF_FFFF);

        // div 7 / -2 = -3 rem 1
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_negb_hi", bus.hi, 32'h0000_0001);

        // divu 100 / 7 = 14 rem 2
        run_op(2'b11, 32'd100, 32'd7, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("divu_lo",   bus.lo, 32'd14);
        check("divu_hi",   bus.hi, 32'd2);
        check("divu_dbz",  dbz, 0);

        // mthi+mtlo together, then separately
        mwrite(1'b1, 1'b1, 32'h0000_0055);
        check("wboth_hi", bus.hi, 32'h55);
        check("wboth_lo", bus.lo, 32'h55);
        mwrite(1'b1, 1'b0, 32'h0000_0011);
        check("mthi_hi", bus.hi, 32'h11);
        check("mthi_lo", bus.lo, 32'h55);
        mwrite(1'b0, 1'b1, 32'h0000_0022);
        check("mtlo_lo", bus.lo, 32'h22);

        // div 5 / 0 with a concurrent mthi/mtlo that start must override
        run_op(2'b10, 32'd5, 32'd0, 1'b1, 32'h0000_0099, 0, lat, busy_n, dbz, hold_bad);
        check("dbz_lat",  lat, 1);
        check("dbz_flag", dbz, 1);
        check("dbz_busy", busy_n, 0);
        check("dbz_hi",   bus.hi, 32'h11);
        check("dbz_lo",   bus.lo, 32'h22);

        // most-negative / -1 wraps
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, 0, lat, busy_n, dbz, hold_bad);
        check("minneg_lo", bus.lo, 32'h8000_0000);
        check("minneg_hi", bus.hi, 32'h0000_0000);

        // multu 6 * 7 with start + mthi injected in cycle 10
        run_op(2'b01, 32'd6, 32'd7, 1'b0, '0, 10, lat, busy_n, dbz, hold_bad);
        check("intf_lat",  lat, 34);
        check("intf_hold", hold_bad, 0);
        check("intf_hi",   bus.hi, 32'd0);
        check("intf_lo",   bus.lo, 32'd42);

        // reset in cycle 15 of a divu aborts it
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_busy_pre", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_hi",   bus.hi, 0);
        check("abort_lo",   bus.lo, 0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
